// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared types and constants for the iterative divider
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } div_op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10,
    S_DONE = 2'b11
  } div_state_e;

  localparam int DIV_LATENCY = 34;

  // funct3[0] clear selects the signed variants, funct3[1] set selects remainder.
  function automatic logic op_is_signed(input div_op_e op);
    return ~op[0];
  endfunction

  function automatic logic op_is_rem(input div_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/div_restore_step.sv
// rtl/div_restore_step.sv - one radix-2 restoring iteration on magnitudes
module div_restore_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem_i,
  input  logic [XLEN-1:0] q_i,
  input  logic [XLEN-1:0] b_i,
  output logic [XLEN-1:0] rem_o,
  output logic [XLEN-1:0] q_o
);

  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // One extra bit: the shifted partial remainder can reach 2*b-1.
  always_comb begin
    shifted = {rem_i, q_i[XLEN-1]};
    diff    = shifted - {1'b0, b_i};
    if (!diff[XLEN]) begin
      rem_o = diff[XLEN-1:0];
      q_o   = {q_i[XLEN-2:0], 1'b1};
    end else begin
      rem_o = shifted[XLEN-1:0];
      q_o   = {q_i[XLEN-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iterative_divider.sv
// rtl/iterative_divider.sv - multi-cycle RV32M DIV/DIVU/REM/REMU unit
// Optional early completion for trivial operands under DIV_EARLY_OUT_EN.
module iterative_divider #(
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  input  logic [4:0]      rd_in,
  input  logic            flush,
  output logic            busy,
  output logic            div_ready,
  output logic [XLEN-1:0] divres,
  output logic [4:0]      rd_out
);

  import div_pkg::*;

  div_state_e       state_q, state_d;
  div_op_e          op_in, op_q;
  logic [CNT_W-1:0] cnt_q;
  logic [XLEN-1:0]  rem_q, quo_q, b_q;
  logic [XLEN-1:0]  rem_nx, quo_nx;
  logic             neg_q_q, neg_r_q, div0_q;
  logic [4:0]       rd_q;
  logic [XLEN-1:0]  divres_q;
  logic [4:0]       rd_out_q;

  logic             accept;
  logic             signed_in;
  logic [XLEN-1:0]  abs_a, abs_b;
  logic [XLEN-1:0]  q_fixed, r_fixed, fix_res;
  logic             early_take;
  logic [XLEN-1:0]  early_res;

  assign op_in     = div_op_e'(op);
  assign signed_in = op_is_signed(op_in);
  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign abs_a     = (signed_in && dividend[XLEN-1]) ? -dividend : dividend;
  assign abs_b     = (signed_in && divisor[XLEN-1])  ? -divisor  : divisor;

`ifdef DIV_EARLY_OUT_EN
  // Zero divisor or a dividend smaller than the divisor needs no iteration.
  always_comb begin
    early_take = (divisor == '0) || (abs_a < abs_b);
    if (op_is_rem(op_in)) begin
      early_res = dividend;
    end else if (divisor == '0) begin
      early_res = '1;
    end else begin
      early_res = '0;
    end
  end
`else
  assign early_take = 1'b0;
  assign early_res  = '0;
`endif

  div_restore_step #(.XLEN(XLEN)) u_step (
    .rem_i (rem_q),
    .q_i   (quo_q),
    .b_i   (b_q),
    .rem_o (rem_nx),
    .q_o   (quo_nx)
  );

  always_comb begin
    q_fixed = neg_q_q ? -quo_q : quo_q;
    r_fixed = neg_r_q ? -rem_q : rem_q;
    if (op_is_rem(op_q)) begin
      fix_res = r_fixed;
    end else if (div0_q) begin
      fix_res = '1;
    end else begin
      fix_res = q_fixed;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d = early_take ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (flush) begin
          state_d = S_IDLE;
        end else if (cnt_q == '0) begin
          state_d = S_FIX;
        end
      end
      S_FIX:   state_d = flush ? S_IDLE : S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = (state_q != S_IDLE);
    div_ready = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_DIV;
      cnt_q    <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      b_q      <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      div0_q   <= 1'b0;
      rd_q     <= '0;
      divres_q <= '0;
      rd_out_q <= '0;
    end else begin
      if (accept) begin
        op_q    <= op_in;
        cnt_q   <= CNT_W'(XLEN - 1);
        rem_q   <= '0;
        quo_q   <= abs_a;
        b_q     <= abs_b;
        neg_q_q <= signed_in && (dividend[XLEN-1] ^ divisor[XLEN-1]);
        neg_r_q <= signed_in && dividend[XLEN-1];
        div0_q  <= (divisor == '0);
        rd_q    <= rd_in;
        if (early_take) begin
          divres_q <= early_res;
          rd_out_q <= rd_in;
        end
      end
      if (state_q == S_CALC && !flush) begin
        rem_q <= rem_nx;
        quo_q <= quo_nx;
        cnt_q <= cnt_q - 1'b1;
      end
      if (state_q == S_FIX && !flush) begin
        divres_q <= fix_res;
        rd_out_q <= rd_q;
      end
    end
  end

  assign divres = divres_q;
  assign rd_out = rd_out_q;

endmodule

// File: tb/tb_iterative_divider.sv
// tb/tb_iterative_divider.sv - self-checking bench for iterative_divider
module tb_iterative_divider;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] dividend = '0;
  logic [31:0] divisor = '0;
  logic [4:0]  rd_in = '0;
  logic        busy, div_ready;
  logic [31:0] divres;
  logic [4:0]  rd_out;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] last_res = '0;
  logic [4:0]  last_rd = '0;

  iterative_divider dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .op        (op),
    .dividend  (dividend),
    .divisor   (divisor),
    .rd_in     (rd_in),
    .flush     (flush),
    .busy      (busy),
    .div_ready (div_ready),
    .divres    (divres),
    .rd_out    (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // RISC-V semantics via 64-bit signed arithmetic, which truncates toward zero.
  function automatic logic [31:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'h0, a});
    ub = longint'({32'h0, b});
    if (b == 32'h0) return o[1] ? a : 32'hFFFF_FFFF;
    case (o)
      2'b00:   r = sa / sb;
      2'b01:   r = ua / ub;
      2'b10:   r = sa % sb;
      default: r = ua % ub;
    endcase
    return r[31:0];
  endfunction

  function automatic int ref_latency(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint ma, mb;
    ma = o[0] ? longint'({32'h0, a}) : longint'($signed(a));
    mb = o[0] ? longint'({32'h0, b}) : longint'($signed(b));
    if (ma < 0) ma = -ma;
    if (mb < 0) mb = -mb;
`ifdef DIV_EARLY_OUT_EN
    if (b == 32'h0 || ma < mb) return 1;
`endif
    return 34;
  endfunction

  // Ends on the falling edge inside cycle T+1.
  task automatic launch(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    op = o; dividend = a; divisor = b; rd_in = rd; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    logic [31:0] exp;
    int          k;
    exp = ref_result(o, a, b);
    launch(o, a, b, rd);
    check("busy_t1", {31'h0, busy}, 32'h1);
    k = 1;
    while (!div_ready && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("latency", k, ref_latency(o, a, b));
    check("busy_at_ready", {31'h0, busy}, 32'h1);
    check("divres", divres, exp);
    check("rd_out", {27'h0, rd_out}, {27'h0, rd});
    last_res = exp;
    last_rd  = rd;
    @(negedge clk);
    check("ready_one_cycle", {31'h0, div_ready}, 32'h0);
    check("idle_after", {31'h0, busy}, 32'h0);
  endtask

  task automatic count_ready(input int cycles, output int cnt, output logic [31:0] res, output logic [4:0] rd);
    cnt = 0; res = '0; rd = '0;
    repeat (cycles) begin
      @(negedge clk);
      if (div_ready) begin
        cnt++;
        res = divres;
        rd  = rd_out;
      end
    end
  endtask

  initial begin
    int          cnt;
    logic [31:0] res;
    logic [4:0]  rd;
    logic [31:0] a, b;

    repeat (2) @(negedge clk);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_ready", {31'h0, div_ready}, 32'h0);
    check("rst_divres", divres, 32'h0);
    check("rst_rd_out", {27'h0, rd_out}, 32'h0);
    rst_n = 1'b1;

    do_op(2'b01, 32'd100, 32'd7, 5'd5);
    do_op(2'b00, -32'sd7, 32'd2, 5'd1);
    do_op(2'b10, -32'sd7, 32'd2, 5'd2);
    do_op(2'b11, 32'd7, 32'hFFFF_FFFE, 5'd3);
    do_op(2'b00, 32'd5, 32'd0, 5'd4);
    do_op(2'b10, -32'sd5, 32'd0, 5'd6);
    do_op(2'b01, 32'd5, 32'd0, 5'd8);
    do_op(2'b11, 32'hDEAD_BEEF, 32'd0, 5'd9);
    do_op(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10);
    do_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11);
    do_op(2'b01, 32'd3, 32'd9, 5'd12);

    // Flush mid-calculation, then a fresh operation.
    launch(2'b01, 32'd9, 32'd3, 5'd13);
    repeat (8) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    count_ready(45, cnt, res, rd);
    check("flush_no_ready", cnt, 0);
    check("flush_divres", divres, last_res);
    check("flush_rd_out", {27'h0, rd_out}, {27'h0, last_rd});
    do_op(2'b11, 32'd9, 32'd4, 5'd14);

    // Second start while busy must be dropped.
    launch(2'b01, 32'd20, 32'd3, 5'd7);
    repeat (4) @(negedge clk);
    op = 2'b00; dividend = 32'd50; divisor = 32'd5; rd_in = 5'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    count_ready(50, cnt, res, rd);
    check("busy_start_count", cnt, 1);
    check("busy_start_res", res, 32'd6);
    check("busy_start_rd", {27'h0, rd}, 32'd7);
    last_res = 32'd6;
    last_rd  = 5'd7;

    // Flush beats start in IDLE.
    @(negedge clk);
    op = 2'b01; dividend = 32'd40; divisor = 32'd8; rd_in = 5'd15; start = 1'b1; flush = 1'b1;
    @(negedge clk);
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {31'h0, busy}, 32'h0);
    count_ready(40, cnt, res, rd);
    check("flush_start_no_ready", cnt, 0);
    check("flush_start_divres", divres, last_res);

    // Asynchronous reset mid-operation.
    launch(2'b11, 32'd1000, 32'd7, 5'd11);
    repeat (19) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("areset_busy", {31'h0, busy}, 32'h0);
    check("areset_ready", {31'h0, div_ready}, 32'h0);
    check("areset_divres", divres, 32'h0);
    check("areset_rd_out", {27'h0, rd_out}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    count_ready(40, cnt, res, rd);
    check("areset_no_ready", cnt, 0);

    for (int i = 0; i < 20; i++) begin
      a = $urandom;
      case ($urandom_range(0, 3))
        0:       b = $urandom;
        1:       b = $urandom_range(1, 20);
        2:       b = 32'h0;
        default: b = a + $urandom_range(1, 1000);
      endcase
      do_op(2'($urandom_range(0, 3)), a, b, 5'($urandom_range(0, 31)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
